// File: rtl/instr_fetch.sv
// Instruction fetch front end: drives the memory address from the PC, captures the
// returned byte into a small prefetch FIFO and hands it to decode with valid/ready.
module instr_fetch #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 8,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               halted,
    output logic [15:0]        fetch_count
);

    // Handshake: an entry leaves the FIFO on any rising edge where out_valid && out_ready;
    // out_valid never depends on out_ready, and a pop coinciding with a redirect still counts as consumed.

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [15:0]        fetch_count_q, fetch_count_d;
    logic [ADDR_W-1:0]  fifo_pc_q    [DEPTH];
    logic [INSTR_W-1:0] fifo_instr_q [DEPTH];
    logic               push;
    logic               pop;

    always_comb begin
        pop           = (count_q != '0) && out_ready;
        push          = (state_q == FETCH) && !halt && !redirect_valid && (count_q != FULL);
        state_d       = state_q;
        pc_d          = pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        fetch_count_d = fetch_count_q;

        if (redirect_valid) begin
            // A redirect keeps the FSM where it is, except that a released halt is still honoured.
            if (state_q == HALT && !halt) begin
                state_d = FETCH;
            end
            pc_d     = redirect_pc;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            case (state_q)
                FETCH:   if (halt)  state_d = HALT;
                HALT:    if (!halt) state_d = FETCH;
                default: state_d = FETCH;
            endcase
            if (push) begin
                pc_d          = pc_q + 1'b1;
                wr_ptr_d      = wr_ptr_q + 1'b1;
                fetch_count_d = fetch_count_q + 16'd1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (!push && pop) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            fetch_count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_q[i]    <= '0;
                fifo_instr_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            fetch_count_q <= fetch_count_d;
            if (push) begin
                fifo_pc_q[wr_ptr_q]    <= pc_q;
                fifo_instr_q[wr_ptr_q] <= mem_instr;
            end
        end
    end

    assign mem_addr    = pc_q;
    assign out_valid   = (count_q != '0);
    assign out_instr   = fifo_instr_q[rd_ptr_q];
    assign out_pc      = fifo_pc_q[rd_ptr_q];
    assign halted      = (state_q == HALT);
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed plus randomised bench for instr_fetch: a reference fetcher model feeds an
// expected-entry queue that is checked against every accepted output.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_instr;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_instr;
    logic [7:0]  out_pc;
    logic        halted;
    logic [15:0] fetch_count;

    logic [7:0]  mem [0:255];
    logic [15:0] exp_q[$];
    logic [7:0]  m_pc;
    logic        m_halt;
    logic [15:0] m_fc;
    int          n_vec;
    int          n_err;

    instr_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .mem_addr       (mem_addr),
        .mem_instr      (mem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    assign mem_instr = mem[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check current outputs, advance the model by one edge, then move to the next falling edge.
    task automatic step();
        logic [15:0] entry;
        int          cnt;
        chk("mem_addr", 32'(mem_addr), 32'(m_pc));
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        chk("halted", 32'(halted), 32'(m_halt));
        chk("fetch_count", 32'(fetch_count), 32'(m_fc));
        cnt = exp_q.size();
        if (!rst && cnt != 0 && out_ready) begin
            entry = exp_q.pop_front();
            chk("out_entry", 32'({out_pc, out_instr}), 32'(entry));
        end
        if (rst) begin
            exp_q.delete();
            m_pc   = 8'h00;
            m_halt = 1'b0;
            m_fc   = 16'd0;
        end else if (redirect_valid) begin
            exp_q.delete();
            m_pc = redirect_pc;
            if (m_halt && !halt) m_halt = 1'b0;
        end else begin
            if (!m_halt && !halt && cnt < 2) begin
                exp_q.push_back({m_pc, mem[m_pc]});
                m_pc = m_pc + 8'd1;
                m_fc = m_fc + 16'd1;
            end
            if (!m_halt && halt) m_halt = 1'b1;
            else if (m_halt && !halt) m_halt = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
        mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3; mem[3] = 8'hD4; mem[4] = 8'hE5;
        mem[8'h40] = 8'h7F;

        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 8'h00; halt = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_instr", 32'(out_instr), 32'h0);
        chk("rst_out_pc", 32'(out_pc), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_fetch_count", 32'(fetch_count), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        m_pc = 8'h00; m_halt = 1'b0; m_fc = 16'd0; exp_q.delete();

        // Streaming with decode always ready.
        repeat (6) step();
        chk("stream_head", 32'({out_pc, out_instr}), 32'h05_00 | 32'(mem[5]));

        // Decode stalled from reset: FIFO fills to two entries then fetch stops.
        rst = 1'b1; step(); rst = 1'b0;
        out_ready = 1'b0;
        repeat (5) step();
        chk("stall_fetch_count", 32'(fetch_count), 32'd2);
        chk("stall_mem_addr", 32'(mem_addr), 32'h02);
        chk("stall_head", 32'({out_pc, out_instr}), 32'h00A1);
        out_ready = 1'b1;
        repeat (4) step();

        // Redirect while streaming at pc 0x03.
        rst = 1'b1; step(); rst = 1'b0;
        repeat (3) step();
        chk("pre_redirect_pc", 32'(mem_addr), 32'h03);
        redirect_valid = 1'b1; redirect_pc = 8'h40;
        step();
        redirect_valid = 1'b0;
        chk("post_redirect_valid", 32'(out_valid), 32'h0);
        step();
        chk("redirect_target", 32'({out_pc, out_instr}), 32'h407F);
        repeat (2) step();

        // Wrap-around of the PC.
        redirect_valid = 1'b1; redirect_pc = 8'hFE;
        step();
        redirect_valid = 1'b0;
        repeat (5) step();

        // Halt with two entries buffered.
        out_ready = 1'b0;
        repeat (2) step();
        out_ready = 1'b1; halt = 1'b1;
        repeat (4) step();
        chk("halt_drained", 32'(out_valid), 32'h0);
        halt = 1'b0;
        repeat (4) step();

        // Randomised traffic.
        for (int i = 0; i < 60; i++) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            halt           = ($urandom_range(0, 5) == 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = 8'($urandom_range(0, 255));
            step();
        end
        redirect_valid = 1'b0; halt = 1'b0;

        // Reset mid-stream with a full FIFO.
        out_ready = 1'b0;
        repeat (3) step();
        rst = 1'b1; step(); rst = 1'b0;
        chk("midrst_out_valid", 32'(out_valid), 32'h0);
        chk("midrst_mem_addr", 32'(mem_addr), 32'h0);
        chk("midrst_fetch_count", 32'(fetch_count), 32'h0);
        chk("midrst_halted", 32'(halted), 32'h0);
        out_ready = 1'b1;
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
